thrd_req_queue: RTL and testbench



---
 rtl/thrd_req_queue_pkg.sv | 23 ++
 rtl/thrd_req_fifo.sv | 65 ++++++
 rtl/thrd_req_queue.sv | 147 ++++++++++++++
 tb/tb_thrd_req_queue.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/thrd_req_queue_pkg.sv
// Shared definitions for the thread fork/stop request queue.
// Holds the inter-cpu message codes, table op encoding and FSM states.
// No logic lives here; consumers import it with import thrd_req_queue_pkg::*.
package thrd_req_queue_pkg;

   // Inter-cpu message codes exchanged with the per-core thread controller
   localparam logic [7:0] CPU_R_FORK_THRD = 8'h10;
   localparam logic [7:0] CPU_R_STOP_THRD = 8'h11;
   localparam logic [7:0] CPU_R_FORK_DONE = 8'h12;
   localparam logic [7:0] CPU_R_STOP_DONE = 8'h13;

   // Thread-table operation encoding
   localparam logic TBL_OP_FORK = 1'b0;
   localparam logic TBL_OP_STOP = 1'b1;

   // Serialiser FSM states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_REPLY = 2'd2
   } state_e;

endpackage

// File: rtl/thrd_req_fifo.sv
// Purpose: synchronous in-order FIFO of W-bit entries, DEPTH slots (power of two).
// Latency: a pushed entry is visible on head one cycle after the push edge.
// Backpressure: push is accepted when not full, or when full with a pop the same cycle.
module thrd_req_fifo #(
   parameter int W     = 65,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] push_dat,
   input  logic         pop,
   output logic         full,
   output logic         empty,
   output logic [W-1:0] head
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

   logic [PW:0]  wr_ptr_q, wr_ptr_d;
   logic [PW:0]  rd_ptr_q, rd_ptr_d;
   logic [W-1:0] mem_q [DEPTH];
   logic [W-1:0] mem_d [DEPTH];
   logic         do_push;
   logic         do_pop;

   // The extra pointer MSB separates full (MSBs differ) from empty (MSBs equal)
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                    (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign head    = mem_q[rd_ptr_q[PW-1:0]];

   // Next-state for storage and pointers; the pop frees the slot a full push lands in
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      mem_d    = mem_q;
      if (do_push) begin
         mem_d[wr_ptr_q[PW-1:0]] = push_dat;
         wr_ptr_d                = wr_ptr_q + PTR_ONE;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
   end

   // State registers, cleared asynchronously
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         mem_q    <= mem_d;
      end
   end

endmodule

// File: rtl/thrd_req_queue.sv
// Purpose: queue pulsed fork/stop requests, issue them in order on the thread-table port, answer with DONE.
// Latency: push at E0 -> tbl_req after E1; ack at Ek -> DONE for REPLY_CYCLES cycles after Ek.
// Backpressure: tbl_req held until tbl_ack; requests arriving on a full queue are dropped and flag overflow.
module thrd_req_queue
   import thrd_req_queue_pkg::*;
#(
   parameter int AW           = 32,
   parameter int DW           = 32,
   parameter int MW           = 8,
   parameter int DEPTH        = 4,
   parameter int REPLY_CYCLES = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cpu_msg_pulse,
   input  logic [MW-1:0] cpu_msg_in,
   input  logic [AW-1:0] addr_in,
   input  logic [DW-1:0] data_in,
   output logic [MW-1:0] cpu_msg_out,
   output logic          tbl_req,
   output logic          tbl_op,
   output logic [AW-1:0] tbl_addr,
   output logic [DW-1:0] tbl_data,
   input  logic          tbl_ack,
   output logic          busy,
   output logic          overflow
);

   localparam int EW = 1 + AW + DW;
   localparam int CW = $clog2(REPLY_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(REPLY_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

   state_e        state_q, state_d;
   logic          op_q, op_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] data_q, data_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          overflow_q, overflow_d;

   logic          is_fork;
   logic          is_stop;
   logic          push_req;
   logic [EW-1:0] push_dat;
   logic          pop;
   logic          full;
   logic          empty;
   logic [EW-1:0] head;
   logic          head_op;
   logic [AW-1:0] head_addr;
   logic [DW-1:0] head_data;
   logic          tbl_req_c;
   logic [MW-1:0] msg_out_c;

   // Only the two request codes are captured; any other pulsed code is ignored
   assign is_fork  = cpu_msg_pulse && (cpu_msg_in == MW'(CPU_R_FORK_THRD));
   assign is_stop  = cpu_msg_pulse && (cpu_msg_in == MW'(CPU_R_STOP_THRD));
   assign push_req = is_fork | is_stop;
   assign push_dat = {(is_stop ? TBL_OP_STOP : TBL_OP_FORK), addr_in, data_in};
   assign pop      = (state_q == ST_IDLE) && !empty;

   assign {head_op, head_addr, head_data} = head;

   thrd_req_fifo #(
      .W     (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push_req),
      .push_dat (push_dat),
      .pop      (pop),
      .full     (full),
      .empty    (empty),
      .head     (head)
   );

   // A request is lost only when full and the FSM is not freeing a slot this cycle
   assign overflow_d = overflow_q | (push_req && full && !pop);

   // Next-state, working-register load and handshake/reply outputs
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      addr_d    = addr_q;
      data_d    = data_q;
      cnt_d     = cnt_q;
      tbl_req_c = 1'b0;
      msg_out_c = '0;
      case (state_q)
         ST_IDLE: begin
            if (!empty) begin
               op_d    = head_op;
               addr_d  = head_addr;
               data_d  = head_data;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            tbl_req_c = 1'b1;
            if (tbl_ack) begin
               cnt_d   = '0;
               state_d = ST_REPLY;
            end
         end
         ST_REPLY: begin
            msg_out_c = (op_q == TBL_OP_STOP) ? MW'(CPU_R_STOP_DONE) : MW'(CPU_R_FORK_DONE);
            cnt_d     = cnt_q + CNT_ONE;
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // FSM, working registers and sticky overflow, all cleared asynchronously
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         op_q       <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
         cnt_q      <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         cnt_q      <= cnt_d;
         overflow_q <= overflow_d;
      end
   end

   assign tbl_req     = tbl_req_c;
   assign tbl_op      = op_q;
   assign tbl_addr    = addr_q;
   assign tbl_data    = data_q;
   assign cpu_msg_out = msg_out_c;
   assign overflow    = overflow_q;
   assign busy        = (state_q != ST_IDLE) | !empty;

endmodule

// File: tb/tb_thrd_req_queue.sv
// Scoreboard bench for thrd_req_queue: directed requests push expected table ops,
// a negedge monitor checks each table issue and each DONE reply as it appears.
// An ack responder answers tbl_req after a programmable number of cycles.
module tb_thrd_req_queue;
   import thrd_req_queue_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cpu_msg_pulse = 1'b0;
   logic [7:0]  cpu_msg_in = '0;
   logic [31:0] addr_in = '0;
   logic [31:0] data_in = '0;
   logic [7:0]  cpu_msg_out;
   logic        tbl_req;
   logic        tbl_op;
   logic [31:0] tbl_addr;
   logic [31:0] tbl_data;
   logic        tbl_ack = 1'b0;
   logic        busy;
   logic        overflow;

   typedef struct {
      logic        op;
      logic [31:0] addr;
      logic [31:0] data;
      int          req_len;   // expected tbl_req high cycles, 0 = not checked
   } exp_t;

   exp_t exp_q[$];
   logic reply_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   ack_wait = 0;
   logic ack_hold = 1'b0;

   always #5 clk = ~clk;

   thrd_req_queue dut (
      .clk           (clk),
      .rst           (rst),
      .cpu_msg_pulse (cpu_msg_pulse),
      .cpu_msg_in    (cpu_msg_in),
      .addr_in       (addr_in),
      .data_in       (data_in),
      .cpu_msg_out   (cpu_msg_out),
      .tbl_req       (tbl_req),
      .tbl_op        (tbl_op),
      .tbl_addr      (tbl_addr),
      .tbl_data      (tbl_data),
      .tbl_ack       (tbl_ack),
      .busy          (busy),
      .overflow      (overflow)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic expect_op(input logic op, input logic [31:0] a, input logic [31:0] d, input int len);
      exp_t e;
      e.op = op; e.addr = a; e.data = d; e.req_len = len;
      exp_q.push_back(e);
   endtask

   // One pulsed message; returns at E0+1 where E0 is the capture edge
   task automatic send(input logic [7:0] code, input logic [31:0] a, input logic [31:0] d);
      @(posedge clk); #1;
      cpu_msg_pulse = 1'b1; cpu_msg_in = code; addr_in = a; data_in = d;
      @(posedge clk); #1;
      cpu_msg_pulse = 1'b0; cpu_msg_in = '0; addr_in = '0; data_in = '0;
   endtask

   // n forks on consecutive edges: addr 0x1000+16*i, data i+1
   task automatic burst(input int n);
      @(posedge clk); #1;
      for (int i = 0; i < n; i++) begin
         if (i != 0) begin
            @(posedge clk); #1;
         end
         cpu_msg_pulse = 1'b1; cpu_msg_in = CPU_R_FORK_THRD;
         addr_in = 32'h1000 + 32'(i * 16); data_in = 32'(i + 1);
      end
      @(posedge clk); #1;
      cpu_msg_pulse = 1'b0; cpu_msg_in = '0; addr_in = '0; data_in = '0;
   endtask

   task automatic wait_idle(input string nm, input int max);
      int n = 0;
      while ((busy || cpu_msg_out != 0 || exp_q.size() != 0 || reply_q.size() != 0) && n < max) begin
         @(negedge clk);
         n++;
      end
      chk(nm, 64'(n < max), 64'd1);
   endtask

   // Ack responder: raise tbl_ack after tbl_req has been high ack_wait cycles
   initial begin
      int rc;
      rc = 0;
      forever begin
         @(posedge clk); #1;
         if (tbl_req && !ack_hold && !rst) begin
            if (rc >= ack_wait) tbl_ack = 1'b1;
            else begin
               tbl_ack = 1'b0;
               rc++;
            end
         end else begin
            tbl_ack = 1'b0;
            rc = 0;
         end
      end
   end

   // Monitor: compare each table issue and each DONE run against the scoreboard
   initial begin
      logic       prev_req;
      logic       stable;
      exp_t       cur;
      int         rlen;
      int         run_len;
      logic [7:0] run_code;
      prev_req = 1'b0; stable = 1'b1; rlen = 0; run_len = 0; run_code = '0;
      cur.op = 1'b0; cur.addr = '0; cur.data = '0; cur.req_len = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_req = 1'b0; rlen = 0; run_len = 0;
            reply_q.delete();
         end else begin
            if (tbl_req && !prev_req) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_issue", 64'd1, 64'd0);
                  cur.op = 1'b0; cur.addr = tbl_addr; cur.data = tbl_data; cur.req_len = 0;
               end else begin
                  cur = exp_q.pop_front();
                  chk("issue_op", 64'(tbl_op), 64'(cur.op));
                  chk("issue_addr", 64'(tbl_addr), 64'(cur.addr));
                  chk("issue_data", 64'(tbl_data), 64'(cur.data));
               end
               rlen = 1; stable = 1'b1;
            end else if (tbl_req) begin
               rlen++;
               if (tbl_op !== cur.op || tbl_addr !== cur.addr || tbl_data !== cur.data) stable = 1'b0;
            end else if (prev_req) begin
               chk("req_stable", 64'(stable), 64'd1);
               if (cur.req_len != 0) chk("req_len", 64'(rlen), 64'(cur.req_len));
               reply_q.push_back(cur.op);
            end
            prev_req = tbl_req;

            if (cpu_msg_out != 0) begin
               if (run_len != 0 && cpu_msg_out != run_code) chk("done_code_change", 64'(cpu_msg_out), 64'(run_code));
               run_code = cpu_msg_out;
               run_len++;
            end else if (run_len != 0) begin
               if (reply_q.size() == 0) chk("unexpected_done", 64'(run_code), 64'd0);
               else begin
                  logic op;
                  op = reply_q.pop_front();
                  chk("done_code", 64'(run_code), 64'(op ? 8'h13 : 8'h12));
               end
               chk("done_len", 64'(run_len), 64'd2);
               run_len = 0;
            end
         end
      end
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

   // Directed stimulus
   initial begin
      int n;
      // Reset state
      #12;
      chk("rst_msg_out", 64'(cpu_msg_out), 64'd0);
      chk("rst_tbl_req", 64'(tbl_req), 64'd0);
      chk("rst_tbl_op", 64'(tbl_op), 64'd0);
      chk("rst_tbl_addr", 64'(tbl_addr), 64'd0);
      chk("rst_tbl_data", 64'(tbl_data), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_overflow", 64'(overflow), 64'd0);
      @(negedge clk); rst = 1'b0;
      repeat (2) @(negedge clk);

      // Single fork, ack on the first ISSUE edge
      ack_wait = 0;
      expect_op(1'b0, 32'h100, 32'h200, 1);
      send(CPU_R_FORK_THRD, 32'h100, 32'h200);
      chk("fork_req_at_e0", 64'(tbl_req), 64'd0);
      chk("fork_busy_at_e0", 64'(busy), 64'd1);
      @(posedge clk); #1;
      chk("fork_req_at_e1", 64'(tbl_req), 64'd1);
      wait_idle("fork_idle", 40);

      // Stop with zero data, tbl_req held 5 cycles
      ack_wait = 4;
      expect_op(1'b1, 32'h0F0, 32'h0, 5);
      send(CPU_R_STOP_THRD, 32'h0F0, 32'h0);
      wait_idle("stop_idle", 60);

      // Non-request codes
      send(CPU_R_FORK_DONE, 32'h55, 32'h66);
      send(8'hAB, 32'h77, 32'h88);
      repeat (3) @(negedge clk);
      chk("nonreq_busy", 64'(busy), 64'd0);
      chk("nonreq_msg_out", 64'(cpu_msg_out), 64'd0);
      chk("nonreq_req", 64'(tbl_req), 64'd0);

      // Overflow: six forks back to back, ack withheld; entry 5 is dropped
      @(negedge clk); ack_hold = 1'b1; ack_wait = 0;
      for (int i = 0; i < 5; i++) expect_op(1'b0, 32'h1000 + 32'(i * 16), 32'(i + 1), (i == 0) ? 0 : 1);
      burst(6);
      chk("ovf_flag", 64'(overflow), 64'd1);
      chk("ovf_req_held", 64'(tbl_req), 64'd1);
      chk("ovf_head_addr", 64'(tbl_addr), 64'h1000);
      repeat (3) @(negedge clk);
      ack_hold = 1'b0;
      wait_idle("ovf_drain", 200);
      chk("ovf_sticky", 64'(overflow), 64'd1);

      // Reset in the middle of a handshake with two entries queued
      @(negedge clk); ack_hold = 1'b1;
      expect_op(1'b0, 32'h2000, 32'h1, 0);
      send(CPU_R_FORK_THRD, 32'h2000, 32'h1);
      send(CPU_R_STOP_THRD, 32'h2010, 32'h2);
      send(CPU_R_FORK_THRD, 32'h2020, 32'h3);
      chk("mid_req_before", 64'(tbl_req), 64'd1);
      #2; rst = 1'b1; #1;
      chk("mid_rst_req", 64'(tbl_req), 64'd0);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_overflow", 64'(overflow), 64'd0);
      chk("mid_rst_msg_out", 64'(cpu_msg_out), 64'd0);
      chk("mid_rst_addr", 64'(tbl_addr), 64'd0);
      repeat (2) @(negedge clk);
      exp_q.delete();
      rst = 1'b0; ack_hold = 1'b0;
      repeat (10) @(negedge clk);
      chk("no_replay_busy", 64'(busy), 64'd0);
      chk("no_replay_req", 64'(tbl_req), 64'd0);

      // Full queue: pulse lands on the edge where IDLE pops the head
      @(negedge clk); ack_hold = 1'b1; ack_wait = 0;
      for (int i = 0; i < 5; i++) expect_op(1'b0, 32'h1000 + 32'(i * 16), 32'(i + 1), (i == 0) ? 0 : 1);
      expect_op(1'b1, 32'h3000, 32'h9, 1);
      burst(5);
      chk("full_no_ovf", 64'(overflow), 64'd0);
      @(negedge clk); ack_hold = 1'b0;
      n = 0;
      while (cpu_msg_out == 0 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk("full_first_done", 64'(n < 50), 64'd1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("full_back_idle", 64'(cpu_msg_out), 64'd0);
      cpu_msg_pulse = 1'b1; cpu_msg_in = CPU_R_STOP_THRD; addr_in = 32'h3000; data_in = 32'h9;
      @(posedge clk); #1;
      cpu_msg_pulse = 1'b0; cpu_msg_in = '0; addr_in = '0; data_in = '0;
      chk("full_pushpop_ovf", 64'(overflow), 64'd0);
      wait_idle("full_drain", 200);
      chk("full_final_ovf", 64'(overflow), 64'd0);

      chk("end_exp_empty", 64'(exp_q.size()), 64'd0);
      chk("end_reply_empty", 64'(reply_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
